// File: rtl/ooo_queue_pkg.sv
// Shared types for the decode-to-execute issue queue.
// Payload layout and scalar functional-unit tags.
package ooo_queue_pkg;

  typedef enum logic [2:0] {
    SFU_ARITH = 3'd0,
    SFU_MULT  = 3'd1,
    SFU_DIV   = 3'd2,
    SFU_LSU   = 3'd3,
    SFU_NONE  = 3'd7
  } scalar_fu_t;

  localparam int FU_ARITH = int'(SFU_ARITH);
  localparam int FU_MULT  = int'(SFU_MULT);
  localparam int FU_DIV   = int'(SFU_DIV);
  localparam int FU_LSU   = int'(SFU_LSU);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [63:0] ctrl;
  } decode_execute_payload_t;

  localparam int PAYLOAD_W = $bits(decode_execute_payload_t);

endpackage

// File: rtl/ooo_circ_buffer.sv
// Circular buffer with wrap-bit pointers.
// Push, pop and clear; storage itself is not reset.
module ooo_circ_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear && !rst)
      mem_q[wr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) &&
                 (wr_q[AW] != rd_q[AW]);
  assign count = wr_q - rd_q;

endmodule

// File: rtl/ooo_decode_execute_queue.sv
// Decode-to-execute issue queue: FU stall gating,
// optional empty-queue bypass and halt serialisation.
module ooo_decode_execute_queue
  import ooo_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = PAYLOAD_W,
  parameter int FU_W   = 3,
  parameter int NUM_FU = 4,
  parameter bit BYPASS = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic [DATA_W-1:0]      dec_data,
  input  logic [FU_W-1:0]        dec_sfu,
  input  logic                   dec_halt,
  input  logic [NUM_FU-1:0]      fu_stall,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [DATA_W-1:0]      ex_data,
  output logic [FU_W-1:0]        ex_sfu,
  output logic                   ex_halt,
  output logic [$clog2(DEPTH):0] count,
  output logic                   halted
);

  localparam int EW = DATA_W + FU_W + 1;

  logic              kill;
  logic              empty, full;
  logic              push, pop;
  logic              enq, deq;
  logic              byp;
  logic              stall_hd, stall_dec;
  logic              halt_q, halt_d;
  logic [EW-1:0]     hd_ent;
  logic [DATA_W-1:0] hd_data;
  logic [FU_W-1:0]   hd_sfu;
  logic              hd_halt;

  assign kill = flush | RST;
  assign {hd_halt, hd_sfu, hd_data} = hd_ent;

  // Tags outside the stall vector never stall.
  always_comb begin
    stall_hd  = 1'b0;
    stall_dec = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (hd_sfu == FU_W'(i))  stall_hd  = fu_stall[i];
      if (dec_sfu == FU_W'(i)) stall_dec = fu_stall[i];
    end
  end

  assign byp = BYPASS && empty;

  assign dec_ready = !full && !halt_q && !kill;

  always_comb begin
    ex_valid = !empty && !stall_hd && !kill;
    ex_data  = hd_data;
    ex_sfu   = hd_sfu;
    ex_halt  = hd_halt;
    if (byp) begin
      ex_valid = dec_valid && !stall_dec && !halt_q && !kill;
      ex_data  = dec_data;
      ex_sfu   = dec_sfu;
      ex_halt  = dec_halt;
    end
  end

  assign enq  = dec_valid && dec_ready;
  assign deq  = ex_valid && ex_ready;
  assign push = enq && !(byp && deq);
  assign pop  = deq && !byp;

  always_comb begin
    halt_d = halt_q;
    if (kill)                  halt_d = 1'b0;
    else if (enq && dec_halt)  halt_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    halt_q <= halt_d;
  end

  assign halted = halt_q && empty;

  ooo_circ_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_buf (
    .clk   (CLK),
    .rst   (RST),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({dec_halt, dec_sfu, dec_data}),
    .rdata (hd_ent),
    .empty (empty),
    .full  (full),
    .count (count)
  );

endmodule
